// File: rtl/count_wrap_monitor.sv
// Observer for a CNT_W-bit up/down counter: flags wrap-arounds, direction changes,
// keeps a saturating wrap count. Step legality checking is built when COUNT_WRAP_STEP_CHECK_EN is defined.
module count_wrap_monitor #(
   parameter int CNT_W  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d,
   input  logic [CNT_W-1:0]  count,
   input  logic              clr,
   output logic              wrap_up,
   output logic              wrap_dn,
   output logic              dir_chg,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              fault,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
   localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  prev_count_q, prev_count_d;
   logic              prev_d_q, prev_d_d;
   logic              wrap_up_q, wrap_up_d;
   logic              wrap_dn_q, wrap_dn_d;
   logic              dir_chg_q, dir_chg_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic              fault_q, fault_d;

   logic              is_up_wrap;
   logic              is_dn_wrap;

   assign is_up_wrap = prev_d_q && (prev_count_q == CNT_MAX) && (count == CNT_ZERO);
   assign is_dn_wrap = !prev_d_q && (prev_count_q == CNT_ZERO) && (count == CNT_MAX);

`ifdef COUNT_WRAP_STEP_CHECK_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   logic [CNT_W-1:0] exp_count;
   logic             step_bad;

   // The counter moves by one per edge in the direction it was given on the previous edge.
   assign exp_count = prev_d_q ? (prev_count_q + CNT_ONE) : (prev_count_q - CNT_ONE);
   assign step_bad  = (count != exp_count);
`endif

   always_comb begin
      state_d      = state_q;
      prev_count_d = prev_count_q;
      prev_d_d     = prev_d_q;
      wrap_up_d    = 1'b0;
      wrap_dn_d    = 1'b0;
      dir_chg_d    = 1'b0;
      wrap_cnt_d   = wrap_cnt_q;
      fault_d      = fault_q;

      case (state_q)
         ST_INIT: begin
            // First sample after reset only primes the history; nothing is judged yet.
            prev_count_d = count;
            prev_d_d     = d;
            if (clr) begin
               wrap_cnt_d = '0;
               fault_d    = 1'b0;
            end
            state_d = ST_TRACK;
         end
         ST_TRACK, ST_FAULT: begin
            prev_count_d = count;
            prev_d_d     = d;
            wrap_up_d    = is_up_wrap;
            wrap_dn_d    = is_dn_wrap;
            dir_chg_d    = (d != prev_d_q);

            if (clr) begin
               wrap_cnt_d = '0;
            end else if ((is_up_wrap || is_dn_wrap) && (wrap_cnt_q != WRAP_MAX)) begin
               wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
            end

`ifdef COUNT_WRAP_STEP_CHECK_EN
            // clr dominates a coincident bad step: the step is simply dropped.
            if (clr) begin
               fault_d = 1'b0;
               state_d = ST_TRACK;
            end else if ((state_q == ST_TRACK) && step_bad) begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end
`else
            fault_d = 1'b0;
            state_d = ST_TRACK;
`endif
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         prev_count_q <= '0;
         prev_d_q     <= 1'b0;
         wrap_up_q    <= 1'b0;
         wrap_dn_q    <= 1'b0;
         dir_chg_q    <= 1'b0;
         wrap_cnt_q   <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_count_q <= prev_count_d;
         prev_d_q     <= prev_d_d;
         wrap_up_q    <= wrap_up_d;
         wrap_dn_q    <= wrap_dn_d;
         dir_chg_q    <= dir_chg_d;
         wrap_cnt_q   <= wrap_cnt_d;
         fault_q      <= fault_d;
      end
   end

   assign wrap_up   = wrap_up_q;
   assign wrap_dn   = wrap_dn_q;
   assign dir_chg   = dir_chg_q;
   assign wrap_cnt  = wrap_cnt_q;
   assign fault     = fault_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: a sample-history model checked every cycle,
// plus hand-computed literal checkpoints; a second instance with WRAP_W=2 covers saturation.
module tb_count_wrap_monitor;

   logic       clk;
   logic       rst;
   logic       d;
   logic [3:0] count;
   logic       clr;

   logic       wrap_up, wrap_dn, dir_chg, fault;
   logic [7:0] wrap_cnt;
   logic [1:0] dbg_state;
   logic       s_wrap_up, s_wrap_dn, s_dir_chg, s_fault;
   logic [1:0] s_wrap_cnt;
   logic [1:0] s_dbg_state;

`ifdef COUNT_WRAP_STEP_CHECK_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   count_wrap_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
      .clk(clk), .rst(rst), .d(d), .count(count), .clr(clr),
      .wrap_up(wrap_up), .wrap_dn(wrap_dn), .dir_chg(dir_chg),
      .wrap_cnt(wrap_cnt), .fault(fault), .dbg_state(dbg_state)
   );

   count_wrap_monitor #(.CNT_W(4), .WRAP_W(2)) dut_sat (
      .clk(clk), .rst(rst), .d(d), .count(count), .clr(clr),
      .wrap_up(s_wrap_up), .wrap_dn(s_wrap_dn), .dir_chg(s_dir_chg),
      .wrap_cnt(s_wrap_cnt), .fault(s_fault), .dbg_state(s_dbg_state)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: history of (count, d) samples; a sample after the priming one is judged
   // against the previous sample using plain modular arithmetic.
   bit m_valid;
   int m_prev_cnt;
   bit m_prev_d;
   bit e_up, e_dn, e_dir, e_fault;
   int e_wcnt, e_wsat;

   function automatic int next_of(input int pc, input bit pd);
      return pd ? (pc + 1) % 16 : (pc + 15) % 16;
   endfunction

   function automatic bit up_wrap(input int pc, input bit pd, input int c);
      return pd && (pc + 1 == 16) && (c == 0);
   endfunction

   function automatic bit dn_wrap(input int pc, input bit pd, input int c);
      return !pd && (pc - 1 == -1) && (c == 15);
   endfunction

   function automatic int sat_inc(input int v, input int cap, input bit ev);
      return (ev && v < cap) ? v + 1 : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0; m_prev_cnt <= 0; m_prev_d <= 1'b0;
         e_up <= 1'b0; e_dn <= 1'b0; e_dir <= 1'b0; e_fault <= 1'b0;
         e_wcnt <= 0; e_wsat <= 0;
      end else if (!m_valid) begin
         m_valid <= 1'b1; m_prev_cnt <= int'(count); m_prev_d <= d;
         e_up <= 1'b0; e_dn <= 1'b0; e_dir <= 1'b0;
         if (clr) begin
            e_wcnt <= 0; e_wsat <= 0; e_fault <= 1'b0;
         end
      end else begin
         m_prev_cnt <= int'(count); m_prev_d <= d;
         e_up  <= up_wrap(m_prev_cnt, m_prev_d, int'(count));
         e_dn  <= dn_wrap(m_prev_cnt, m_prev_d, int'(count));
         e_dir <= (d != m_prev_d);
         e_wcnt <= clr ? 0 : sat_inc(e_wcnt, 255,
                     up_wrap(m_prev_cnt, m_prev_d, int'(count)) || dn_wrap(m_prev_cnt, m_prev_d, int'(count)));
         e_wsat <= clr ? 0 : sat_inc(e_wsat, 3,
                     up_wrap(m_prev_cnt, m_prev_d, int'(count)) || dn_wrap(m_prev_cnt, m_prev_d, int'(count)));
         e_fault <= clr ? 1'b0 :
                    (e_fault || (STEP_EN && int'(count) != next_of(m_prev_cnt, m_prev_d)));
      end
   end

   // scoreboard: every cycle after the first reset edge
   always @(negedge clk) begin
      if (started) begin
         chk("wrap_up",    32'(wrap_up),    32'(e_up));
         chk("wrap_dn",    32'(wrap_dn),    32'(e_dn));
         chk("dir_chg",    32'(dir_chg),    32'(e_dir));
         chk("wrap_cnt",   32'(wrap_cnt),   32'(e_wcnt));
         chk("fault",      32'(fault),      32'(e_fault));
         chk("sat_wrap_up",  32'(s_wrap_up),  32'(e_up));
         chk("sat_wrap_dn",  32'(s_wrap_dn),  32'(e_dn));
         chk("sat_wrap_cnt", 32'(s_wrap_cnt), 32'(e_wsat));
         chk("sat_fault",    32'(s_fault),    32'(e_fault));
      end
   end

   // driver tasks
   logic [3:0] ctr;
   logic       dir;

   task automatic cyc(input logic [3:0] c, input logic dd, input logic cl, input logic r);
      @(negedge clk);
      count = c; d = dd; clr = cl; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic cl);
      cyc(ctr, dir, cl, 1'b0);
      ctr = dir ? ctr + 4'd1 : ctr - 4'd1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wrap_up"},  32'(wrap_up),  32'd0);
      chk({tag, "_wrap_dn"},  32'(wrap_dn),  32'd0);
      chk({tag, "_dir_chg"},  32'(dir_chg),  32'd0);
      chk({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'd0);
      chk({tag, "_fault"},    32'(fault),    32'd0);
   endtask

   initial begin
      rst = 1'b1; d = 1'b0; count = 4'd0; clr = 1'b0;
      ctr = 4'd0; dir = 1'b1;

      cyc(4'd0, 1'b1, 1'b0, 1'b1);
      started = 1'b1;
      chk_all_zero("reset");

      // continuous count-up: samples 0..15,0,1
      for (int i = 0; i < 18; i++) begin
         tick(1'b0);
         if (i == 16) begin
            chk("up_wrap_pulse", 32'(wrap_up), 32'd1);
            chk("up_wrap_cnt",   32'(wrap_cnt), 32'd1);
         end
         if (i == 17) chk("up_wrap_one_cycle", 32'(wrap_up), 32'd0);
      end

      // direction flip: 2,3,4 then down 3,2,1,0,15
      tick(1'b0); tick(1'b0);
      dir = 1'b0;
      tick(1'b0);
      chk("dir_chg_pulse", 32'(dir_chg), 32'd1);
      tick(1'b0);
      chk("dir_chg_one_cycle", 32'(dir_chg), 32'd0);
      tick(1'b0); tick(1'b0); tick(1'b0);
      tick(1'b0);
      chk("dn_wrap_pulse", 32'(wrap_dn), 32'd1);
      chk("dn_wrap_cnt",   32'(wrap_cnt), 32'd2);
      chk("dn_no_fault",   32'(fault), 32'd0);

      // saturation: five up-wraps, WRAP_W=2 reads 1,2,3,3,3
      cyc(ctr, 1'b1, 1'b0, 1'b1);
      ctr = 4'd0; dir = 1'b1;
      tick(1'b0);
      for (int w = 1; w <= 5; w++) begin
         repeat (16) tick(1'b0);
         chk("sat_cnt",      32'(s_wrap_cnt), 32'((w < 3) ? w : 3));
         chk("sat_pulse",    32'(s_wrap_up),  32'd1);
         chk("main_cnt",     32'(wrap_cnt),   32'(w));
      end

      // clear race: clr on the same edge as a 15->0 wrap with wrap_cnt=2
      cyc(ctr, 1'b1, 1'b0, 1'b1);
      ctr = 4'd0; dir = 1'b1;
      tick(1'b0);
      repeat (32) tick(1'b0);
      chk("race_pre_cnt", 32'(wrap_cnt), 32'd2);
      repeat (15) tick(1'b0);
      tick(1'b1);
      chk("race_wrap_up", 32'(wrap_up),  32'd1);
      chk("race_cnt",     32'(wrap_cnt), 32'd0);
      tick(1'b0);
      chk("race_cnt_hold", 32'(wrap_cnt), 32'd0);

      // illegal step 5->9
      repeat (4) tick(1'b0);
      cyc(4'd9, 1'b1, 1'b0, 1'b0);
      ctr = 4'd10;
      chk("illegal_fault", 32'(fault), 32'(STEP_EN));
      tick(1'b0); tick(1'b0);
      chk("illegal_sticky", 32'(fault), 32'(STEP_EN));
      tick(1'b1);
      chk("clr_fault", 32'(fault), 32'd0);
      tick(1'b0);
      chk("clr_fault_hold", 32'(fault), 32'd0);
      cyc(4'd3, 1'b1, 1'b1, 1'b0);
      ctr = 4'd4;
      chk("clr_beats_illegal", 32'(fault), 32'd0);
      tick(1'b0);
      cyc(4'd8, 1'b1, 1'b0, 1'b0);
      ctr = 4'd9;
      chk("check_resumes", 32'(fault), 32'(STEP_EN));
      tick(1'b1);

      // mid-operation reset with wrap_cnt=3 and fault set
      repeat (48) tick(1'b0);
      chk("pre_rst_cnt", 32'(wrap_cnt), 32'd3);
      cyc(4'd2, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_fault", 32'(fault), 32'(STEP_EN));
      cyc(4'd2, 1'b1, 1'b1, 1'b1);
      chk_all_zero("midrst");
      cyc(4'd12, 1'b1, 1'b0, 1'b0);
      chk_all_zero("init_jump");
      cyc(4'd13, 1'b1, 1'b0, 1'b0);
      chk_all_zero("post_init");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
